mlp_stream_rx: RTL and testbench

- Receive-side endpoint of the DRAM→accelerator load stream: the block that consumes the `ready`/`i_en`/`data_in` word stream a host driver produces.
- One load is started by a one-cycle `start` pulse, then carries a fixed-length sequence of 32-bit words: IFMAP words, then WEIGHT words, then BIAS words.
- The block decodes the phase of each word and routes it to the matching GLB write port with a linear address.
- It signals completion of each load and tracks which layer (step 0 or step 1) was just loaded.

---
 rtl/mlp_stream_rx.sv | 201 ++++++++++++++++++++
 tb/tb_mlp_stream_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_stream_rx.sv
// mlp_stream_rx: receive endpoint of the DRAM-to-accelerator load stream.
//
// A one-cycle start pulse opens a load. The load is a fixed sequence of IFMAP_WORDS
// IFMAP words, then WEIGHT_WORDS WEIGHT words, then BIAS_WORDS BIAS words. Each accepted
// word is written to the GLB port of its phase with a linear word address. All write
// outputs are registered, so a write appears one cycle after its word is accepted.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               load request pulse
//   i_en, data_in       stream word valid / stream word
//   ifmap_we/addr       IFMAP GLB write port
//   weight_we/addr      WEIGHT GLB write port
//   bias_we/addr        BIAS GLB write port
//   wdata               write data shared by the three GLB ports
//   busy                a load is in progress
//   load_done           one-cycle pulse once the whole load has been written
//   layer_idx           index of the next load, toggles on each load_done
//   err_stray           sticky: a word arrived outside a load
//   err_restart         sticky: start arrived during a load
module mlp_stream_rx #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned IFMAP_WORDS  = 16,
    parameter int unsigned WEIGHT_WORDS = 1024,
    parameter int unsigned BIAS_WORDS   = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            i_en,
    input  logic [DATA_W-1:0]               data_in,
    output logic                            ifmap_we,
    output logic [$clog2(IFMAP_WORDS)-1:0]  ifmap_addr,
    output logic                            weight_we,
    output logic [$clog2(WEIGHT_WORDS)-1:0] weight_addr,
    output logic                            bias_we,
    output logic [$clog2(BIAS_WORDS)-1:0]   bias_addr,
    output logic [DATA_W-1:0]               wdata,
    output logic                            busy,
    output logic                            load_done,
    output logic                            layer_idx,
    output logic                            err_stray,
    output logic                            err_restart
);

    localparam int unsigned IfmapAw  = $clog2(IFMAP_WORDS);
    localparam int unsigned WeightAw = $clog2(WEIGHT_WORDS);
    localparam int unsigned BiasAw   = $clog2(BIAS_WORDS);
    // One counter serves all phases, so it is sized for the widest address.
    localparam int unsigned CntW = (WeightAw >= IfmapAw && WeightAw >= BiasAw) ? WeightAw :
                                   ((IfmapAw >= BiasAw) ? IfmapAw : BiasAw);

    localparam logic [CntW-1:0] IfmapLast  = CntW'(IFMAP_WORDS - 1);
    localparam logic [CntW-1:0] WeightLast = CntW'(WEIGHT_WORDS - 1);
    localparam logic [CntW-1:0] BiasLast   = CntW'(BIAS_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIfmap,
        StWeight,
        StBias,
        StDone
    } state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [CntW-1:0]       cnt_d;
    logic                  ifmap_we_q;
    logic [IfmapAw-1:0]    ifmap_addr_q;
    logic                  weight_we_q;
    logic [WeightAw-1:0]   weight_addr_q;
    logic                  bias_we_q;
    logic [BiasAw-1:0]     bias_addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  busy_q;
    logic                  load_done_q;
    logic                  layer_idx_q;
    logic                  err_stray_q;
    logic                  err_restart_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            ifmap_we_q    <= 1'b0;
            ifmap_addr_q  <= '0;
            weight_we_q   <= 1'b0;
            weight_addr_q <= '0;
            bias_we_q     <= 1'b0;
            bias_addr_q   <= '0;
            wdata_q       <= '0;
            busy_q        <= 1'b0;
            load_done_q   <= 1'b0;
            layer_idx_q   <= 1'b0;
            err_stray_q   <= 1'b0;
            err_restart_q <= 1'b0;
        end else begin
            // Write strobes and load_done are single-cycle pulses.
            ifmap_we_q  <= 1'b0;
            weight_we_q <= 1'b0;
            bias_we_q   <= 1'b0;
            load_done_q <= 1'b0;

            // A start during a load is flagged but otherwise ignored.
            if (start && state_q != StIdle) begin
                err_restart_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    // Any word seen here is dropped, even one coincident with start.
                    if (i_en) begin
                        err_stray_q <= 1'b1;
                    end
                    if (start) begin
                        state_q <= StIfmap;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                StIfmap: begin
                    if (i_en) begin
                        ifmap_we_q   <= 1'b1;
                        ifmap_addr_q <= cnt_q[IfmapAw-1:0];
                        wdata_q      <= data_in;
                        if (cnt_q == IfmapLast) begin
                            state_q <= StWeight;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end

                StWeight: begin
                    if (i_en) begin
                        weight_we_q   <= 1'b1;
                        weight_addr_q <= cnt_q[WeightAw-1:0];
                        wdata_q       <= data_in;
                        if (cnt_q == WeightLast) begin
                            state_q <= StBias;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end

                StBias: begin
                    if (i_en) begin
                        bias_we_q   <= 1'b1;
                        bias_addr_q <= cnt_q[BiasAw-1:0];
                        wdata_q     <= data_in;
                        if (cnt_q == BiasLast) begin
                            state_q <= StDone;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end

                StDone: begin
                    // The final bias write is visible during this state; load_done,
                    // the layer toggle and busy clearing all land one cycle later.
                    if (i_en) begin
                        err_stray_q <= 1'b1;
                    end
                    load_done_q <= 1'b1;
                    layer_idx_q <= ~layer_idx_q;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ifmap_we    = ifmap_we_q;
    assign ifmap_addr  = ifmap_addr_q;
    assign weight_we   = weight_we_q;
    assign weight_addr = weight_addr_q;
    assign bias_we     = bias_we_q;
    assign bias_addr   = bias_addr_q;
    assign wdata       = wdata_q;
    assign busy        = busy_q;
    assign load_done   = load_done_q;
    assign layer_idx   = layer_idx_q;
    assign err_stray   = err_stray_q;
    assign err_restart = err_restart_q;

endmodule

// File: tb/tb_mlp_stream_rx.sv
// Self-checking bench for mlp_stream_rx: expected GLB writes are queued as words are
// driven and compared as the DUT writes them.
module tb_mlp_stream_rx;

    localparam int unsigned DataW   = 32;
    localparam int unsigned NIfmap  = 16;
    localparam int unsigned NWeight = 1024;
    localparam int unsigned NBias   = 64;
    localparam int unsigned NTotal  = NIfmap + NWeight + NBias;

    logic              clk;
    logic              rst;
    logic              start;
    logic              i_en;
    logic [DataW-1:0]  data_in;
    logic              ifmap_we;
    logic [3:0]        ifmap_addr;
    logic              weight_we;
    logic [9:0]        weight_addr;
    logic              bias_we;
    logic [5:0]        bias_addr;
    logic [DataW-1:0]  wdata;
    logic              busy;
    logic              load_done;
    logic              layer_idx;
    logic              err_stray;
    logic              err_restart;

    mlp_stream_rx #(
        .DATA_W      (DataW),
        .IFMAP_WORDS (NIfmap),
        .WEIGHT_WORDS(NWeight),
        .BIAS_WORDS  (NBias)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .i_en       (i_en),
        .data_in    (data_in),
        .ifmap_we   (ifmap_we),
        .ifmap_addr (ifmap_addr),
        .weight_we  (weight_we),
        .weight_addr(weight_addr),
        .bias_we    (bias_we),
        .bias_addr  (bias_addr),
        .wdata      (wdata),
        .busy       (busy),
        .load_done  (load_done),
        .layer_idx  (layer_idx),
        .err_stray  (err_stray),
        .err_restart(err_restart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned done_cnt;
    logic        exp_layer;
    logic        prev_bias_last;

    // Expected write: {kind[1:0], addr[9:0], data[31:0]}; kind 1=ifmap 2=weight 3=bias.
    logic [43:0] sb_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [43:0] exp_write(input int unsigned k, input logic [31:0] d);
        logic [1:0] kind;
        logic [9:0] addr;
        if (k < NIfmap) begin
            kind = 2'd1;
            addr = 10'(k);
        end else if (k < NIfmap + NWeight) begin
            kind = 2'd2;
            addr = 10'(k - NIfmap);
        end else begin
            kind = 2'd3;
            addr = 10'(k - NIfmap - NWeight);
        end
        return {kind, addr, d};
    endfunction

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            logic [43:0] obs;
            logic [43:0] exp;
            if (ifmap_we || weight_we || bias_we) begin
                check_eq("we_onehot", 64'($countones({ifmap_we, weight_we, bias_we})), 64'd1);
                if (ifmap_we)       obs = {2'd1, 6'd0, ifmap_addr, wdata};
                else if (weight_we) obs = {2'd2, weight_addr, wdata};
                else                obs = {2'd3, 4'd0, bias_addr, wdata};
                if (sb_q.size() == 0) begin
                    check_eq("wr_unexpected", 64'(obs), 64'd0);
                end else begin
                    exp = sb_q.pop_front();
                    check_eq("wr", 64'(obs), 64'(exp));
                end
            end
            // load_done must follow the bias addr 63 write by exactly one cycle.
            if (prev_bias_last || load_done) begin
                check_eq("done_lat", 64'(load_done), 64'(prev_bias_last));
            end
            if (load_done) done_cnt++;
            prev_bias_last = bias_we && (bias_addr == 6'(NBias - 1));
        end else begin
            prev_bias_last = 1'b0;
        end
    end

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (load_done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("done_seen", 64'(seen), 64'd1);
        exp_layer = ~exp_layer;
        check_eq("layer_idx", 64'(layer_idx), 64'(exp_layer));
        check_eq("busy_clear", 64'(busy), 64'd0);
    endtask

    // Drive one load: words 0..stop_at-1 with data base+k; optional 3-cycle gap after
    // every 7th word and an optional start pulse coincident with word restart_at.
    task automatic run_load(input logic [31:0] base, input bit gaps, input int restart_at,
                            input int unsigned stop_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_set", 64'(busy), 64'd1);
        for (int unsigned k = 0; k < stop_at; k++) begin
            i_en    = 1'b1;
            data_in = base + k;
            if (int'(k) == restart_at) start = 1'b1;
            sb_q.push_back(exp_write(k, base + k));
            tick();
            start = 1'b0;
            if (gaps && (k % 7 == 6)) begin
                i_en = 1'b0;
                repeat (3) tick();
            end
        end
        if (stop_at == NTotal) begin
            i_en = 1'b0;
            wait_done();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        done_cnt       = 0;
        exp_layer      = 1'b0;
        prev_bias_last = 1'b0;
        rst            = 1'b1;
        start          = 1'b0;
        i_en           = 1'b0;
        data_in        = '0;
        repeat (3) tick();
        check_eq("reset_outs", 64'({ifmap_we, ifmap_addr, weight_we, weight_addr, bias_we,
                                    bias_addr, busy, load_done, layer_idx, err_stray,
                                    err_restart}), 64'd0);
        check_eq("reset_wdata", 64'(wdata), 64'd0);
        rst = 1'b0;
        tick();

        // Continuous load, data = index.
        run_load(32'd0, 1'b0, -1, NTotal);
        // Same stream with gaps.
        tick();
        run_load(32'd0, 1'b1, -1, NTotal);
        // Back-to-back loads, start the cycle after load_done.
        tick();
        run_load(32'h0001_0000, 1'b0, -1, NTotal);
        tick();
        run_load(32'h0002_0000, 1'b0, -1, NTotal);
        check_eq("no_err_stray", 64'(err_stray), 64'd0);
        check_eq("no_err_restart", 64'(err_restart), 64'd0);

        // Stray word in IDLE, then start coincident with a word.
        tick();
        i_en    = 1'b1;
        data_in = 32'hDEAD_BEEF;
        tick();
        i_en = 1'b0;
        check_eq("stray_flag", 64'(err_stray), 64'd1);
        check_eq("stray_busy", 64'(busy), 64'd0);
        i_en = 1'b1;
        run_load(32'h0003_0000, 1'b0, -1, NTotal);
        check_eq("stray_sticky", 64'(err_stray), 64'd1);
        check_eq("stray_no_restart", 64'(err_restart), 64'd0);

        // Async reset at BIAS word 10, asserted between clock edges.
        tick();
        run_load(32'h0004_0000, 1'b0, -1, NIfmap + NWeight + 11);
        i_en = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_we", 64'({ifmap_we, weight_we, bias_we}), 64'd0);
        check_eq("arst_addr", 64'({ifmap_addr, weight_addr, bias_addr}), 64'd0);
        check_eq("arst_wdata", 64'(wdata), 64'd0);
        check_eq("arst_flags", 64'({busy, load_done, layer_idx, err_stray, err_restart}),
                 64'd0);
        sb_q.delete();
        exp_layer = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        check_eq("arst_no_done", 64'(done_cnt), 64'd5);
        run_load(32'h0005_0000, 1'b0, -1, NTotal);

        // Start pulse at WEIGHT word 500.
        tick();
        run_load(32'h0006_0000, 1'b0, int'(NIfmap) + 500, NTotal);
        check_eq("restart_flag", 64'(err_restart), 64'd1);
        check_eq("restart_no_stray", 64'(err_stray), 64'd0);

        repeat (5) tick();
        check_eq("sb_left", 64'(sb_q.size()), 64'd0);
        check_eq("done_total", 64'(done_cnt), 64'd7);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
